// File: rtl/alu_serial_frontend.sv
// Bit-serial host front end for the 8-bit ALU: deserializes {op, a, b}, drives the ALU, serializes the result.
// Optional even-parity frame check is enabled by defining ALU_SERIAL_FRONTEND_PARITY_EN.
module alu_serial_frontend #(
  parameter int DATA_W  = 8,
  parameter int OP_W    = 2,
  parameter int ALU_LAT = 1,
  parameter int TX_DIV  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_bit,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  output logic              tx_bit,
  output logic              tx_valid,
  output logic              tx_last,
  output logic              busy,
  output logic              overrun,
  output logic              parity_err,
  output logic [1:0]        state_dbg
);

  localparam int FRAME_LEN = OP_W + 2 * DATA_W;
`ifdef ALU_SERIAL_FRONTEND_PARITY_EN
  localparam int RX_LEN = FRAME_LEN + 1;
`else
  localparam int RX_LEN = FRAME_LEN;
`endif
  localparam int CNT_MAX = (RX_LEN + 1 > ALU_LAT) ? RX_LEN + 1 : ALU_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int DIV_W   = (TX_DIV > 1) ? $clog2(TX_DIV) : 1;
  localparam int BIT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {
    ST_RX   = 2'd0,
    ST_WAIT = 2'd1,
    ST_TX   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [FRAME_LEN-1:0]  frame_q, frame_d;
  logic [FRAME_LEN-1:0]  frame_next;
  logic [FRAME_LEN-1:0]  load_data;
  logic [OP_W-1:0]       op_q, op_d;
  logic [DATA_W-1:0]     a_q, a_d;
  logic [DATA_W-1:0]     b_q, b_d;
  logic [DATA_W-1:0]     tx_sr_q, tx_sr_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic                  overrun_q, overrun_d;
  logic                  perr_q, perr_d;
  logic                  frame_ok;

  // Bits arrive LSB first, so shifting in at the top leaves op in the low bits.
  assign frame_next = {rx_bit, frame_q[FRAME_LEN-1:1]};
`ifdef ALU_SERIAL_FRONTEND_PARITY_EN
  assign load_data = frame_q;
  assign frame_ok  = ~((^frame_q) ^ rx_bit);
`else
  assign load_data = frame_next;
  assign frame_ok  = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    frame_d   = frame_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    tx_sr_d   = tx_sr_q;
    div_d     = div_q;
    bit_d     = bit_q;
    perr_d    = 1'b0;
    overrun_d = overrun_q | (rx_valid && (state_q != ST_RX));
    case (state_q)
      ST_RX: begin
        if (rx_valid) begin
          if (cnt_q == CNT_W'(RX_LEN - 1)) begin
            cnt_d = '0;
            if (frame_ok) begin
              op_d    = load_data[OP_W-1:0];
              a_d     = load_data[OP_W+DATA_W-1:OP_W];
              b_d     = load_data[FRAME_LEN-1:OP_W+DATA_W];
              state_d = ST_WAIT;
            end else begin
              perr_d = 1'b1;
            end
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            frame_d = frame_next;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == CNT_W'(ALU_LAT - 1)) begin
          tx_sr_d = alu_result;
          cnt_d   = '0;
          div_d   = '0;
          bit_d   = '0;
          state_d = ST_TX;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_TX: begin
        // Each bit owns a TX_DIV-cycle window; advance only at the window's end.
        if (div_q == DIV_W'(TX_DIV - 1)) begin
          div_d   = '0;
          tx_sr_d = tx_sr_q >> 1;
          if (bit_q == BIT_W'(DATA_W - 1)) begin
            state_d = ST_RX;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: state_d = ST_RX;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RX;
      cnt_q     <= '0;
      frame_q   <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      tx_sr_q   <= '0;
      div_q     <= '0;
      bit_q     <= '0;
      overrun_q <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      frame_q   <= frame_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      tx_sr_q   <= tx_sr_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      overrun_q <= overrun_d;
      perr_q    <= perr_d;
    end
  end

  assign rx_ready   = (state_q == ST_RX);
  assign busy       = (state_q == ST_WAIT) || (state_q == ST_TX);
  assign alu_op     = op_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign tx_bit     = (state_q == ST_TX) & tx_sr_q[0];
  assign tx_valid   = (state_q == ST_TX) && (div_q == '0);
  assign tx_last    = tx_valid && (bit_q == BIT_W'(DATA_W - 1));
  assign overrun    = overrun_q;
  assign parity_err = perr_q;
  assign state_dbg  = state_q;

endmodule
